// File: rtl/mm6532_port_cond_pkg.sv
// Shared definitions for the 6532 RIOT port conditioner: SWCHA/SWCHB bit
// positions, default parameter values, the raw-contact bundle layout and
// the SWCHB packing helper.
package mm6532_port_cond_pkg;

  // SWCHA (PA_IN) bit positions
  localparam int P0_RIGHT = 7;
  localparam int P0_LEFT  = 6;
  localparam int P0_DOWN  = 5;
  localparam int P0_UP    = 4;
  localparam int P1_RIGHT = 3;
  localparam int P1_LEFT  = 2;
  localparam int P1_DOWN  = 1;
  localparam int P1_UP    = 0;

  // SWCHB (PB_IN) bit positions; bits 5, 4 and 2 are unused and read 1
  localparam int SWB_RESET  = 0;
  localparam int SWB_SELECT = 1;
  localparam int SWB_COLOUR = 3;
  localparam int SWB_P0DIFF = 6;
  localparam int SWB_P1DIFF = 7;

  // Default parameter values
  localparam int         DEF_TICK_DIV       = 1000;
  localparam int         DEF_DEBOUNCE_TICKS = 8;
  localparam logic [4:0] DEF_TOGGLE_MASK    = 5'b11100;
  localparam logic [4:0] DEF_TOGGLE_INIT    = 5'b00100;

  // Number of conditioned raw contacts (2 x 4 joystick + 5 switches)
  localparam int N_RAW = 13;

  // Layout of the 13-bit raw / debounced vectors used inside the top
  typedef struct packed {
    logic [3:0] joy0;  // {right,left,down,up}
    logic [3:0] joy1;  // {right,left,down,up}
    logic [4:0] sw;    // {p1_diff,p0_diff,colour,select,reset}
  } raw_t;

  // Place the five switch states into their SWCHB positions
  function automatic logic [7:0] swchb_pack(input logic [4:0] s);
    logic [7:0] b;
    b             = 8'hFF;
    b[SWB_RESET]  = s[0];
    b[SWB_SELECT] = s[1];
    b[SWB_COLOUR] = s[2];
    b[SWB_P0DIFF] = s[3];
    b[SWB_P1DIFF] = s[4];
    return b;
  endfunction

  // Switch state right after reset: toggled bits take their init value,
  // plain bits read released (1)
  function automatic logic [4:0] sw_reset_state(input logic [4:0] mask,
                                                input logic [4:0] init);
    return (mask & init) | ~mask;
  endfunction

endpackage

// File: rtl/mm6532_port_debounce.sv
// One conditioning cell: 2-flop synchronizer, debounce counter and the
// accepted (debounced) level. Also emits a registered one-cycle strobe in
// the cycle the accepted level has just fallen 1->0, for toggle logic.
module mm6532_port_debounce #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic CLK,
  input  logic RES,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_fall;
  logic          w_y;

  assign w_y = r_sync[1];

  // Synchronize the raw contact and accept a new level only after
  // DEBOUNCE_TICKS consecutive disagreeing ticks
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would collapse the synchronizer into a single stage.
    if (RES) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_fall <= 1'b0;
      if (i_tick) begin
        if (w_y == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_MAX) begin
          r_level <= w_y;
          r_cnt   <= '0;
          r_fall  <= ~w_y;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/mm6532_port_cond.sv
// Input conditioner upstream of the 6532 RIOT ports. Debounces the raw
// joystick and console-switch contacts, turns selected pushbuttons into
// latching toggles, drives the SWCHA/SWCHB-shaped PA_IN/PB_IN buses and
// pulses CHANGED for one cycle whenever either bus takes a new value.
module mm6532_port_cond
  import mm6532_port_cond_pkg::*;
#(
  parameter int         TICK_DIV       = DEF_TICK_DIV,
  parameter int         DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [4:0] TOGGLE_MASK    = DEF_TOGGLE_MASK,
  parameter logic [4:0] TOGGLE_INIT    = DEF_TOGGLE_INIT
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [3:0] JOY0_N,
  input  logic [3:0] JOY1_N,
  input  logic [4:0] SW_N,
  output logic [7:0] PA_IN,
  output logic [7:0] PB_IN,
  output logic       CHANGED
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0] SW_RST = sw_reset_state(TOGGLE_MASK, TOGGLE_INIT);

  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [N_RAW-1:0] w_raw;
  logic [N_RAW-1:0] w_level;
  logic [N_RAW-1:0] w_fall;
  raw_t             w_lvl;
  logic [4:0]       w_sw_fall;
  logic [7:0]       w_fall_unused;  // joystick bits never toggle
  logic [4:0]       r_tog;
  logic [4:0]       w_s;
  logic [7:0]       w_pa_next;
  logic [7:0]       w_pb_next;
  logic [7:0]       r_pa;
  logic [7:0]       r_pb;
  logic             r_changed;

  // Raw vector follows the raw_t layout: {joy0, joy1, sw}
  assign w_raw = {JOY0_N, JOY1_N, SW_N};

  // Debounce sample prescaler: one tick every TICK_DIV cycles
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  for (genvar gi = 0; gi < N_RAW; gi++) begin : g_cell
    mm6532_port_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_cell (
      .CLK    (CLK),
      .RES    (RES),
      .i_tick (w_tick),
      .i_raw  (w_raw[gi]),
      .o_level(w_level[gi]),
      .o_fall (w_fall[gi])
    );
  end

  assign w_lvl         = w_level;
  assign w_sw_fall     = w_fall[4:0];
  assign w_fall_unused = w_fall[12:5];

  // Effective switch state. A toggled bit already shows its new value in
  // the cycle its fall strobe is high, so toggled and plain switches reach
  // PB_IN with the same latency.
  assign w_s = (TOGGLE_MASK & (r_tog ^ w_sw_fall)) | (~TOGGLE_MASK & w_lvl.sw);

  // Latching toggle state: flips on each debounced press of a toggle bit
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_tog <= TOGGLE_INIT;
    end else begin
      r_tog <= r_tog ^ (w_sw_fall & TOGGLE_MASK);
    end
  end

  // Map debounced joystick levels onto SWCHA positions
  always_comb begin
    // NOTE: give every combinational output a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_pa_next           = 8'hFF;
    w_pa_next[P0_RIGHT] = w_lvl.joy0[3];
    w_pa_next[P0_LEFT]  = w_lvl.joy0[2];
    w_pa_next[P0_DOWN]  = w_lvl.joy0[1];
    w_pa_next[P0_UP]    = w_lvl.joy0[0];
    w_pa_next[P1_RIGHT] = w_lvl.joy1[3];
    w_pa_next[P1_LEFT]  = w_lvl.joy1[2];
    w_pa_next[P1_DOWN]  = w_lvl.joy1[1];
    w_pa_next[P1_UP]    = w_lvl.joy1[0];
  end

  assign w_pb_next = swchb_pack(w_s);

  // Output registers; CHANGED compares the incoming value against the
  // current one so it rises in the same cycle the new value appears
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_pa      <= 8'hFF;
      r_pb      <= swchb_pack(SW_RST);
      r_changed <= 1'b0;
    end else begin
      r_pa      <= w_pa_next;
      r_pb      <= w_pb_next;
      r_changed <= (w_pa_next != r_pa) || (w_pb_next != r_pb);
    end
  end

  assign PA_IN   = r_pa;
  assign PB_IN   = r_pb;
  assign CHANGED = r_changed;

endmodule

// File: tb/tb_mm6532_port_cond.sv
// Bench for mm6532_port_cond: two instances (TICK_DIV=4/DEBOUNCE_TICKS=3 and
// TICK_DIV=1/DEBOUNCE_TICKS=1) run directed scenarios and randomized contact
// activity, compared every cycle against a behavioural model plus explicit
// expectations for latency, pulse counts and output values.
module tb_mm6532_port_cond;

  localparam logic [4:0] TMASK = 5'b11100;
  localparam logic [4:0] TINIT = 5'b00100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res;
  logic [3:0] joy0 [2];
  logic [3:0] joy1 [2];
  logic [4:0] sw   [2];
  logic [7:0] pa   [2];
  logic [7:0] pb   [2];
  logic       ch   [2];

  mm6532_port_cond #(
    .TICK_DIV(4), .DEBOUNCE_TICKS(3), .TOGGLE_MASK(TMASK), .TOGGLE_INIT(TINIT)
  ) u_dut_a (
    .CLK(clk), .RES(res), .JOY0_N(joy0[0]), .JOY1_N(joy1[0]), .SW_N(sw[0]),
    .PA_IN(pa[0]), .PB_IN(pb[0]), .CHANGED(ch[0])
  );

  mm6532_port_cond #(
    .TICK_DIV(1), .DEBOUNCE_TICKS(1), .TOGGLE_MASK(TMASK), .TOGGLE_INIT(TINIT)
  ) u_dut_b (
    .CLK(clk), .RES(res), .JOY0_N(joy0[1]), .JOY1_N(joy1[1]), .SW_N(sw[1]),
    .PA_IN(pa[1]), .PB_IN(pb[1]), .CHANGED(ch[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  // Raw history is a two-deep delay; a bit's accepted level flips once it
  // has disagreed with the raw history on DT consecutive sample ticks.
  logic [12:0] m_s1 [2];
  logic [12:0] m_s2 [2];
  logic [12:0] m_d  [2];
  int          m_run [2][13];
  logic [4:0]  m_tog [2];
  int          m_cyc [2];
  logic [7:0]  m_pa [2];
  logic [7:0]  m_pb [2];
  logic        m_ch [2];

  function automatic int td_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int dt_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // SWCHB image: {s4,s3,1,1,s2,1,s1,s0}, s = toggle state or plain level
  function automatic logic [7:0] pb_of(input logic [4:0] d, input logic [4:0] tog);
    logic [4:0] s;
    for (int i = 0; i < 5; i++) s[i] = TMASK[i] ? tog[i] : d[i];
    return {s[4], s[3], 1'b1, 1'b1, s[2], 1'b1, s[1], s[0]};
  endfunction

  task automatic model_edge(input int k);
    logic [12:0] y;
    logic [7:0]  pa_n, pb_n;
    bit          tick;
    if (res) begin
      m_s1[k]  = '1;
      m_s2[k]  = '1;
      m_d[k]   = '1;
      for (int i = 0; i < 13; i++) m_run[k][i] = 0;
      m_tog[k] = TINIT;
      m_cyc[k] = 0;
      m_pa[k]  = 8'hFF;
      m_pb[k]  = pb_of(5'b11111, TINIT);
      m_ch[k]  = 1'b0;
      return;
    end
    pa_n    = m_d[k][12:5];
    pb_n    = pb_of(m_d[k][4:0], m_tog[k]);
    m_ch[k] = (pa_n != m_pa[k]) || (pb_n != m_pb[k]);
    m_pa[k] = pa_n;
    m_pb[k] = pb_n;
    tick    = ((m_cyc[k] % td_of(k)) == td_of(k) - 1);
    m_cyc[k]++;
    y = m_s2[k];
    if (tick) begin
      for (int i = 0; i < 13; i++) begin
        if (y[i] != m_d[k][i]) begin
          m_run[k][i]++;
          if (m_run[k][i] == dt_of(k)) begin
            if (i < 5 && TMASK[i] && !y[i]) m_tog[k][i] = ~m_tog[k][i];
            m_d[k][i]   = y[i];
            m_run[k][i] = 0;
          end
        end else begin
          m_run[k][i] = 0;
        end
      end
    end
    m_s2[k] = m_s1[k];
    m_s1[k] = {joy0[k], joy1[k], sw[k]};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One clock: advance model at the edge, compare all outputs mid-cycle
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_pa%0d", k), pa[k], m_pa[k]);
      check($sformatf("model_pb%0d", k), pb[k], m_pb[k]);
      check($sformatf("model_ch%0d", k), {7'd0, ch[k]}, {7'd0, m_ch[k]});
    end
  endtask

  task automatic release_all();
    for (int k = 0; k < 2; k++) begin
      joy0[k] = 4'hF;
      joy1[k] = 4'hF;
      sw[k]   = 5'h1F;
    end
  endtask

  // Run n cycles, report pulses seen on instance k
  task automatic run_count(input int k, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (ch[k]) pulses++;
    end
  endtask

  // Wait (bounded) for PA_IN of instance k to equal v; returns cycle index
  // of first match (0 = never) and pulses seen meanwhile
  task automatic wait_pa(input int k, input logic [7:0] v, input int budget,
                         output int first, output int pulses);
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (ch[k]) pulses++;
      if (first == 0 && pa[k] == v) first = i;
    end
  endtask

  int first, pulses, p2, guard;

  initial begin
    res = 1'b1;
    release_all();

    // 1. reset then idle
    repeat (3) step();
    check("rst_pa", pa[0], 8'hFF);
    check("rst_pb", pb[0], 8'h3F);
    check("rst_ch", {7'd0, ch[0]}, 8'd0);
    res = 1'b0;
    run_count(0, 24, pulses);
    check("idle_pulses", 8'(pulses), 8'd0);
    check("idle_pa", pa[0], 8'hFF);
    check("idle_pb", pb[0], 8'h3F);

    // 2. JOY0 up held, then released
    joy0[0] = 4'b1110;
    wait_pa(0, 8'hEF, 20, first, pulses);
    check("press_seen", 8'(first > 0 && first <= 15), 8'd1);
    check("press_pulses", 8'(pulses), 8'd1);
    joy0[0] = 4'hF;
    wait_pa(0, 8'hFF, 20, first, pulses);
    check("release_seen", 8'(first > 0 && first <= 15), 8'd1);
    check("release_pulses", 8'(pulses), 8'd1);

    // 3. glitch covering exactly two ticks
    joy1[0][3] = 1'b0;
    repeat (8) step();
    joy1[0][3] = 1'b1;
    run_count(0, 20, pulses);
    check("glitch_pulses", 8'(pulses), 8'd0);
    check("glitch_pa", pa[0], 8'hFF);

    // 4. colour toggle and plain reset switch
    sw[0][2] = 1'b0;
    run_count(0, 40, pulses);
    check("tog1_pb", pb[0], 8'h37);
    check("tog1_pulses", 8'(pulses), 8'd1);
    sw[0][2] = 1'b1;
    run_count(0, 40, pulses);
    check("tog1_rel_pb", pb[0], 8'h37);
    check("tog1_rel_pulses", 8'(pulses), 8'd0);
    sw[0][2] = 1'b0;
    run_count(0, 40, pulses);
    check("tog2_pb", pb[0], 8'h3F);
    sw[0][2] = 1'b1;
    run_count(0, 40, pulses);
    sw[0][0] = 1'b0;
    run_count(0, 40, pulses);
    check("plain_held_pb", pb[0], 8'h3E);
    sw[0][0] = 1'b1;
    run_count(0, 40, pulses);
    check("plain_rel_pb", pb[0], 8'h3F);

    // 5. reset while a debounce count is partway
    joy0[0][0] = 1'b0;
    guard = 0;
    while (m_run[0][9] != 2 && guard < 40) begin
      step();
      guard++;
    end
    check("partial_reached", 8'(guard < 40), 8'd1);
    res = 1'b1;
    step();
    check("midrst_pa", pa[0], 8'hFF);
    res = 1'b0;
    wait_pa(0, 8'hEF, 30, first, pulses);
    check("midrst_latency", 8'(first), 8'd13);
    joy0[0][0] = 1'b1;
    run_count(0, 30, pulses);

    // 6. fastest settings: edge to output in four cycles
    joy0[1][0] = 1'b0;
    repeat (3) step();
    check("fast_pa_early", pa[1], 8'hFF);
    check("fast_ch_early", {7'd0, ch[1]}, 8'd0);
    step();
    check("fast_pa", pa[1], 8'hEF);
    check("fast_ch", {7'd0, ch[1]}, 8'd1);
    joy0[1][0] = 1'b1;
    run_count(1, 8, pulses);
    joy0[1] = 4'h0;
    joy1[1] = 4'h0;
    sw[1]   = 5'h00;
    run_count(1, 10, pulses);
    check("all13_pulses", 8'(pulses), 8'd1);
    check("all13_pa", pa[1], 8'h00);
    check("all13_pb", pb[1], 8'hF4);
    release_all();
    run_count(1, 10, p2);
    check("all13_rel_pulses", 8'(p2), 8'd1);

    // Randomized contact activity on both instances, checked every cycle
    for (int seg = 0; seg < 150; seg++) begin
      for (int k = 0; k < 2; k++) begin
        joy0[k] = 4'(~($urandom() & $urandom()));
        joy1[k] = 4'(~($urandom() & $urandom()));
        sw[k]   = 5'(~($urandom() & $urandom()));
      end
      if ($urandom_range(0, 19) == 0) res = 1'b1;
      step();
      res = 1'b0;
      repeat ($urandom_range(1, 40)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
